// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer: loads PE_DIM weight beats into a PE row, then
// broadcasts feature beats, pulsing acc after each one. After the last
// feature it pulses done, captures each column's sum on its out_vd, and
// drains the sums one per valid/ready handshake.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_data, in_addr, in_nnz, in_last  upstream beats
//   data_bus, non_zero_add_bus, non_zero_num, weight_enable_top,
//   broad_cast_enable, acc, done, psum_rd                 row-facing (registered)
//   sum_out_bus, out_vd                                   per-column sums from row
//   out_valid/out_ready, out_data, out_col                result stream
//   busy, timeout_err, perf_cycles                        status
//
// Optional: define PE_ROW_SEQ_PERF_EN to build the perf_cycles counter;
// without it perf_cycles is tied to 0.
module pe_row_sequencer #(
    parameter int MAC_DIM         = 4,
    parameter int FEAT_WIDTH      = 1,
    parameter int PE_OUT_WIDTH    = 8,
    parameter int SPAD_WIDTH      = 64,
    parameter int PE_DIM          = 16,
    parameter int LOG_PE_DIM      = $clog2(PE_DIM),
    parameter int ADDR_WIDTH      = $clog2(SPAD_WIDTH),
    parameter int COLLECT_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH*MAC_DIM-1:0]  in_addr,
    input  logic [1:0]                     in_nnz,
    input  logic                           in_last,
    output logic [FEAT_WIDTH*SPAD_WIDTH-1:0] data_bus,
    output logic [ADDR_WIDTH*MAC_DIM-1:0]  non_zero_add_bus,
    output logic [1:0]                     non_zero_num,
    output logic [LOG_PE_DIM-1:0]          weight_enable_top,
    output logic                           broad_cast_enable,
    output logic                           acc,
    output logic                           done,
    output logic                           psum_rd,
    input  logic [PE_OUT_WIDTH*PE_DIM-1:0] sum_out_bus,
    input  logic [PE_DIM-1:0]              out_vd,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PE_OUT_WIDTH-1:0]        out_data,
    output logic [LOG_PE_DIM-1:0]          out_col,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [31:0]                    perf_cycles
);

    localparam int DW = FEAT_WIDTH * SPAD_WIDTH;
    localparam int AW = ADDR_WIDTH * MAC_DIM;
    localparam int TW = $clog2(COLLECT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEAT,
        S_ACC,
        S_DONE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [LOG_PE_DIM-1:0]   col_cnt_q, col_cnt_d;
    logic                    last_q, last_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [PE_DIM-1:0]       vd_mask_q, vd_mask_d;
    logic [PE_OUT_WIDTH-1:0] res_q [PE_DIM];
    logic [PE_OUT_WIDTH-1:0] res_d [PE_DIM];
    logic [LOG_PE_DIM-1:0]   idx_q, idx_d;
    logic                    in_ready_q, in_ready_d;
    logic [DW-1:0]           data_bus_q, data_bus_d;
    logic [AW-1:0]           nz_add_q, nz_add_d;
    logic [1:0]              nz_num_q, nz_num_d;
    logic [LOG_PE_DIM-1:0]   wen_q, wen_d;
    logic                    bce_q, bce_d;
    logic                    acc_q, acc_d;
    logic                    done_q, done_d;
    logic                    psum_rd_q, psum_rd_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    terr_q, terr_d;

    logic accept;
    logic hs;

    assign accept = in_valid && in_ready_q;
    assign hs     = out_valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        last_d    = last_q;
        timer_d   = timer_q;
        vd_mask_d = vd_mask_q;
        res_d     = res_q;
        idx_d     = idx_q;
        data_bus_d = data_bus_q;
        nz_add_d  = nz_add_q;
        nz_num_d  = nz_num_q;
        wen_d     = wen_q;
        bce_d     = 1'b0;
        terr_d    = terr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_bus_d = in_data;
                    wen_d      = '0;
                    col_cnt_d  = LOG_PE_DIM'(1);
                    state_d    = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (accept) begin
                    data_bus_d = in_data;
                    wen_d      = col_cnt_q;
                    col_cnt_d  = col_cnt_q + 1'b1;
                    if (col_cnt_q == LOG_PE_DIM'(PE_DIM - 1)) begin
                        state_d = S_FEAT;
                    end
                end
            end
            S_FEAT: begin
                if (accept) begin
                    data_bus_d = in_data;
                    nz_add_d   = in_addr;
                    nz_num_d   = in_nnz;
                    bce_d      = 1'b1;
                    last_d     = in_last;
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                state_d = last_q ? S_DONE : S_FEAT;
            end
            S_DONE: begin
                vd_mask_d = '0;
                timer_d   = '0;
                res_d     = '{default: '0};
                state_d   = S_COLLECT;
            end
            S_COLLECT: begin
                // First out_vd per column wins; later pulses are masked.
                for (int i = 0; i < PE_DIM; i++) begin
                    if (out_vd[i] && !vd_mask_q[i]) begin
                        res_d[i]     = sum_out_bus[i*PE_OUT_WIDTH +: PE_OUT_WIDTH];
                        vd_mask_d[i] = 1'b1;
                    end
                end
                if (&vd_mask_d) begin
                    state_d = S_DRAIN;
                end else if (timer_q == TW'(COLLECT_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (hs) begin
                    if (idx_q == LOG_PE_DIM'(PE_DIM - 1)) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes and status are registered from the next state so they
        // line up exactly with the state they describe.
        in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD_W) ||
                      (state_d == S_FEAT);
        acc_d       = (state_d == S_ACC);
        done_d      = (state_d == S_DONE);
        psum_rd_d   = (state_d == S_DONE) || (state_d == S_COLLECT) ||
                      (state_d == S_DRAIN);
        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            col_cnt_q   <= '0;
            last_q      <= 1'b0;
            timer_q     <= '0;
            vd_mask_q   <= '0;
            res_q       <= '{default: '0};
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            data_bus_q  <= '0;
            nz_add_q    <= '0;
            nz_num_q    <= '0;
            wen_q       <= '0;
            bce_q       <= 1'b0;
            acc_q       <= 1'b0;
            done_q      <= 1'b0;
            psum_rd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
            vd_mask_q   <= vd_mask_d;
            res_q       <= res_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            data_bus_q  <= data_bus_d;
            nz_add_q    <= nz_add_d;
            nz_num_q    <= nz_num_d;
            wen_q       <= wen_d;
            bce_q       <= bce_d;
            acc_q       <= acc_d;
            done_q      <= done_d;
            psum_rd_q   <= psum_rd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign data_bus          = data_bus_q;
    assign non_zero_add_bus  = nz_add_q;
    assign non_zero_num      = nz_num_q;
    assign weight_enable_top = wen_q;
    assign broad_cast_enable = bce_q;
    assign acc               = acc_q;
    assign done              = done_q;
    assign psum_rd           = psum_rd_q;
    assign out_valid         = out_valid_q;
    assign out_col           = idx_q;
    assign out_data          = out_valid_q ? res_q[idx_q] : '0;
    assign busy              = busy_q;
    assign timeout_err       = terr_q;

`ifdef PE_ROW_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && accept) begin
            perf_d = '0;
        end else if (busy_q) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_row_sequencer.sv
// tb_pe_row_sequencer: scoreboard bench for pe_row_sequencer.
// Stimulus tasks push expected result beats; a negedge monitor checks them.
module tb_pe_row_sequencer;

    localparam int PD = 16;
    localparam int OW = 8;
    localparam int DW = 64;
    localparam int AW = 24;
    localparam int LW = 4;
    localparam int TO = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_nnz;
    logic          in_last;
    logic [DW-1:0] data_bus;
    logic [AW-1:0] non_zero_add_bus;
    logic [1:0]    non_zero_num;
    logic [LW-1:0] weight_enable_top;
    logic          broad_cast_enable;
    logic          acc;
    logic          done;
    logic          psum_rd;
    logic [OW*PD-1:0] sum_out_bus;
    logic [PD-1:0] out_vd;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [LW-1:0] out_col;
    logic          busy;
    logic          timeout_err;
    logic [31:0]   perf_cycles;

    pe_row_sequencer #(.COLLECT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr),
        .in_nnz(in_nnz), .in_last(in_last),
        .data_bus(data_bus), .non_zero_add_bus(non_zero_add_bus),
        .non_zero_num(non_zero_num),
        .weight_enable_top(weight_enable_top),
        .broad_cast_enable(broad_cast_enable),
        .acc(acc), .done(done), .psum_rd(psum_rd),
        .sum_out_bus(sum_out_bus), .out_vd(out_vd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_col(out_col),
        .busy(busy), .timeout_err(timeout_err),
        .perf_cycles(perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic [LW-1:0] col;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int acc_cnt, bce_cnt, done_cnt, pop_cnt, coll_cnt, busy_cnt;
    bit acc_prev = 1'b0;
    bit drain_ok = 1'b0;
    bit terr_model = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: scoreboard pops plus per-cycle protocol rules.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (acc) acc_cnt++;
                if (broad_cast_enable) bce_cnt++;
                if (busy) busy_cnt++;
                if (acc) chk("in_ready_low_in_acc", 64'(in_ready), 0);
                if (done) begin
                    done_cnt++;
                    chk("done_after_acc", 64'(acc_prev), 1);
                end
                acc_prev = acc;
                if (psum_rd && !done && !out_valid) coll_cnt++;
                if (out_valid) begin
                    chk("drain_after_capture", 64'(drain_ok), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: col %0d data 0x%0h, expected none",
                                 out_col, out_data);
                    end else begin
                        chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                        chk("out_col", 64'(out_col), 64'(exp_q[0].col));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            pop_cnt++;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_data_bus"}, data_bus, 0);
        chk({tag, "_nz_add"}, 64'(non_zero_add_bus), 0);
        chk({tag, "_nz_num"}, 64'(non_zero_num), 0);
        chk({tag, "_wen"}, 64'(weight_enable_top), 0);
        chk({tag, "_strobes"},
            64'({broad_cast_enable, acc, done, psum_rd}), 0);
        chk({tag, "_out"}, 64'({out_valid, out_data, out_col}), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_timeout_err"}, 64'(timeout_err), 0);
        chk({tag, "_perf"}, 64'(perf_cycles), 0);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [AW-1:0] a,
                             input logic [1:0] n, input bit last,
                             output bit ok);
        bit rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        in_nnz   = n;
        in_last  = last;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    // Column k weight payload is k; in_last on weight beats must be ignored.
    task automatic load_weights();
        bit ok;
        for (int k = 0; k < PD; k++) begin
            send_beat(DW'(k), AW'($urandom), 2'($urandom), (k % 5) == 2, ok);
            chk("weight_col", 64'(weight_enable_top), 64'(k));
            chk("weight_data", data_bus, 64'(k));
        end
    endtask

    task automatic send_feats(input int n);
        bit ok;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [1:0] nn;
        for (int j = 0; j < n; j++) begin
            d  = {$urandom, $urandom};
            a  = AW'($urandom);
            nn = 2'($urandom);
            send_beat(d, a, nn, j == n - 1, ok);
            chk("feat_data", data_bus, d);
            chk("feat_addr", 64'(non_zero_add_bus), 64'(a));
            chk("feat_nnz", 64'(non_zero_num), 64'(nn));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: all columns at once, random sums
    // mode 1: cols 0-7, then 8-15 five cycles later with a repeat on col 3
    // mode 2: cols 0-14 only (timeout), col 15 expected 0
    // mode 3: all at once, column i sum = i+1
    task automatic collect(input int mode);
        logic [OW-1:0] s [PD];
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < PD; i++) begin
            s[i] = (mode == 3) ? OW'(i + 1) : OW'($urandom);
            sum_out_bus[i*OW +: OW] = s[i];
        end
        for (int i = 0; i < PD; i++) begin
            exp_q.push_back('{data: (mode == 2 && i == PD - 1) ? '0 : s[i],
                              col: LW'(i)});
        end
        if (mode == 1) begin
            out_vd = 16'h00FF;
            @(posedge clk);
            #1;
            out_vd = '0;
            sum_out_bus = {$urandom, $urandom, $urandom, $urandom};
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            for (int i = 8; i < PD; i++) sum_out_bus[i*OW +: OW] = s[i];
            sum_out_bus[3*OW +: OW] = 8'hFF;
            drain_ok = 1'b1;
            out_vd = 16'hFF08;
        end else begin
            drain_ok = 1'b1;
            out_vd = (mode == 2) ? 16'h7FFF : 16'hFFFF;
        end
        @(posedge clk);
        #1;
        out_vd = '0;
    endtask

    task automatic drain(input bit toggle);
        bit pat [4];
        bit fin;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        fin = 1'b0;
        for (int c = 0; c < 300; c++) begin
            out_ready = toggle ? pat[c % 4] : 1'b1;
            @(negedge clk);
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy stayed 1, expected 0");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_job(input int nfeat, input int cmode, input bit toggle);
        acc_cnt  = 0;
        bce_cnt  = 0;
        done_cnt = 0;
        pop_cnt  = 0;
        coll_cnt = 0;
        busy_cnt = 0;
        drain_ok = 1'b0;
        load_weights();
        send_feats(nfeat);
        collect(cmode);
        drain(toggle);
        chk("acc_pulses", 64'(acc_cnt), 64'(nfeat));
        chk("bce_pulses", 64'(bce_cnt), 64'(nfeat));
        chk("done_pulses", 64'(done_cnt), 1);
        chk("drain_beats", 64'(pop_cnt), 64'(PD));
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        chk("busy_after_job", 64'(busy), 0);
        chk("psum_rd_after_job", 64'(psum_rd), 0);
        chk("timeout_err", 64'(timeout_err), 64'(terr_model));
        if (cmode == 2) chk("collect_cycles", 64'(coll_cnt), 64'(TO));
`ifdef PE_ROW_SEQ_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(busy_cnt));
`else
        chk("perf_cycles", 64'(perf_cycles), 0);
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_addr     = '0;
        in_nnz      = '0;
        in_last     = 1'b0;
        sum_out_bus = '0;
        out_vd      = '0;
        out_ready   = 1'b0;
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_job(1, 3, 1'b0);
        run_job(3, 0, 1'b0);
        run_job(2, 1, 1'b0);
        run_job(1, 0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            run_job(int'($urandom_range(1, 4)), 0, 1'($urandom));
        end
        terr_model = 1'b1;
        run_job(1, 2, 1'b0);

        // Abort in FEAT: reset acts at once, then a clean job follows.
        load_weights();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midjob_reset");
        exp_q.delete();
        acc_prev = 1'b0;
        terr_model = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_job(2, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
